multi_read_port_ram: RTL and testbench
======================================

// Module: multi_read_port_ram
// PURPOSE
//  Single-write, N-read register-file style RAM for FPGA targets.
//  Generalises the fixed 1W2R async RAM: the read port count is a parameter, reads are
//    combinational or registered, writes use byte enables, and an on-chip clear engine zeroes the array.
//  Used as the register file and small lookup store in pipeline front-ends.
// PARAMETERS
//  ADDR_WIDTH    10    width of every address port
//  DATA_DEPTH    1024  number of words; must satisfy 2**ADDR_WIDTH >= DATA_DEPTH
//  DATA_WIDTH    32    word width; must be a multiple of 8
//  NUM_RD_PORTS  2     number of independent read ports; must be >= 1
//  READ_LATENCY  0     0 = combinational read, 1 = registered read; no other values are legal
//  WRITE_FIRST   1     READ_LATENCY=1 only: same-cycle read of the write address returns the new data
// PORTS
//  Clk_CI       in   1                         clock; all state updates on the rising edge
//  Rst_RI       in   1                         synchronous reset, active-high
//  Clear_SI     in   1                         request a full-array clear (pulse)
//  Busy_SO      out  1                         clear engine active; writes are dropped while high
//  WrEn_SI      in   1                         write enable
//  WrBe_SI      in   DATA_WIDTH/8              write byte enables
//  WrAddr_DI    in   ADDR_WIDTH                write address
//  WrData_DI    in   DATA_WIDTH                write data
//  RdAddr_DI    in   NUM_RD_PORTS*ADDR_WIDTH   read addresses, packed; port i = [i*ADDR_WIDTH +: ADDR_WIDTH]
//  RdData_DO    out  NUM_RD_PORTS*DATA_WIDTH   read data, packed the same way
// BEHAVIOUR
//  Reset
//   - One clock; reset is synchronous and active-high.
//   - Rst_RI high forces state CLEAR, ClrCnt=0 and Busy_SO=1.
//   - Registered read data resets to 0.
//   - Array contents are not reset directly; the clear engine zeroes them.
//  FSM
//   - States: CLEAR, IDLE.
//   - CLEAR: writes 0 to word ClrCnt each cycle and increments ClrCnt.
//   - CLEAR -> IDLE on the cycle ClrCnt==DATA_DEPTH-1 is written.
//   - After Rst_RI falls, Busy_SO is high for exactly DATA_DEPTH cycles.
//   - IDLE -> CLEAR when Clear_SI=1; ClrCnt is set to 0.
//   - Clear_SI is ignored while in CLEAR.
//   - Reset asserted mid-clear restarts the clear from word 0.
//  Busy_SO
//   - Busy_SO = (state==CLEAR), driven from a register.
//  Write (IDLE only)
//   - Condition: WrEn_SI=1 and WrAddr_DI < DATA_DEPTH.
//   - Byte b of the word is updated iff WrBe_SI[b]=1.
//   - WrEn_SI=1 with WrBe_SI=0 leaves the word unchanged.
//   - Writes with WrAddr_DI >= DATA_DEPTH are dropped silently.
//   - Writes while Busy_SO=1 are dropped; there is no back-pressure and the caller must check Busy_SO.
//  Read, READ_LATENCY=0
//   - RdData_DO[i] = mem[RdAddr_DI[i]] combinationally.
//   - A write becomes visible on the cycle after its clock edge (read-before-write).
//  Read, READ_LATENCY=1
//   - RdData_DO[i] is registered; it shows the data for the address presented one cycle earlier.
//   - WRITE_FIRST=1: if a read address equals an accepted write address in the same cycle, the
//     registered data is the old word merged with the new bytes per WrBe_SI.
//   - WRITE_FIRST=0: the registered data is the old word.
//  Read, all modes
//   - Read address >= DATA_DEPTH returns 0.
//   - Reads return 0 while Busy_SO=1, in both latency modes.
//   - All read ports are fully independent, so any number of ports may use the same address.
//  Parameter checks
//   - An elaboration-time check fails if 2**ADDR_WIDTH < DATA_DEPTH.
//   - It also fails if DATA_WIDTH%8 != 0 or if READ_LATENCY is not 0 or 1.
// STRUCTURE
//  Package fpga_ram_pkg holds:
//   - clear_state_e enum {CLEAR, IDLE};
//   - the function be_merge(old, new, be), used for both the array write and the bypass.
//  No sub-module: the FSM, write port and a generate loop over the read ports all live in this file.
// TESTING
//  1. Reset for 1 cycle, DATA_DEPTH=16
//     -> Busy_SO=1 for exactly 16 cycles; every address then reads 0.
//  2. Write 0xDEADBEEF to addr 3 with BE=4'b0101, over 0x11223344
//     -> addr 3 reads 0x11AD33EF.
//  3. NUM_RD_PORTS=4, all ports read addr 5 holding 0xA5A5A5A5
//     -> all four ports return 0xA5A5A5A5 in the same cycle.
//  4. READ_LATENCY=1, WRITE_FIRST=1: write 0x12345678 to addr 7 while port 0 reads addr 7
//     -> next cycle RdData_DO[0]=0x12345678; with WRITE_FIRST=0 it shows the old value.
//  5. Pulse Clear_SI with data stored, then issue a write during the clear
//     -> write is dropped; all words read 0 after Busy_SO falls.
//  6. DATA_DEPTH=12, ADDR_WIDTH=4: write addr 13, then read addr 13
//     -> read returns 0 and addr 13 mod 12 = 1 is unchanged.

Source files
------------

// File: rtl/fpga_ram_pkg.sv
// Shared types and helpers for the multi-read-port register-file RAM.
//   clear_state_e : state of the array clear engine (CLEAR while zeroing, IDLE otherwise)
//   be_merge      : byte-enable merge of a new word into an old word. It is used
//                   both for the array write and for the write-first read bypass,
//                   so the two paths cannot disagree.
//   The helper works on a fixed maximum width. Callers zero-extend their operands
//   and truncate the result back to their own word width.
package fpga_ram_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      IDLE  = 1'b1
   } clear_state_e;

   localparam int MAX_DW = 1024;
   localparam int MAX_NB = MAX_DW / 8;

   function automatic logic [MAX_DW-1:0] be_merge(
      input logic [MAX_DW-1:0] old_word,
      input logic [MAX_DW-1:0] new_word,
      input logic [MAX_NB-1:0] be
   );
      logic [MAX_DW-1:0] res;
      res = old_word;
      for (int b = 0; b < MAX_NB; b++) begin
         if (be[b]) begin
            res[b*8 +: 8] = new_word[b*8 +: 8];
         end else begin
            res[b*8 +: 8] = old_word[b*8 +: 8];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/multi_read_port_ram.sv
// Single-write, N-read register-file RAM with byte enables and an on-chip clear engine.
// Ports:
//   Clk_CI     clock; all state updates on the rising edge
//   Rst_RI     synchronous active-high reset; starts a full clear
//   Clear_SI   pulse to request a full-array clear (ignored while clearing)
//   Busy_SO    high while the clear engine runs; writes are dropped and reads return 0
//   WrEn_SI    write enable
//   WrBe_SI    per-byte write enables
//   WrAddr_DI  write address; addresses >= DATA_DEPTH are dropped
//   WrData_DI  write data
//   RdAddr_DI  packed read addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   RdData_DO  packed read data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
// READ_LATENCY=0 gives combinational reads (read-before-write).
// READ_LATENCY=1 gives registered reads. With WRITE_FIRST=1, these bypass a same-cycle write.
module multi_read_port_ram
   import fpga_ram_pkg::*;
#(
   parameter int ADDR_WIDTH   = 10,
   parameter int DATA_DEPTH   = 1024,
   parameter int DATA_WIDTH   = 32,
   parameter int NUM_RD_PORTS = 2,
   parameter int READ_LATENCY = 0,
   parameter int WRITE_FIRST  = 1
) (
   input  logic                               Clk_CI,
   input  logic                               Rst_RI,
   input  logic                               Clear_SI,
   output logic                               Busy_SO,
   input  logic                               WrEn_SI,
   input  logic [DATA_WIDTH/8-1:0]            WrBe_SI,
   input  logic [ADDR_WIDTH-1:0]              WrAddr_DI,
   input  logic [DATA_WIDTH-1:0]              WrData_DI,
   input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0] RdAddr_DI,
   output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] RdData_DO
);

   localparam int NB = DATA_WIDTH / 8;
   // One extra bit so the depth itself is representable for range compares.
   localparam logic [ADDR_WIDTH:0]   DEPTH_V = (ADDR_WIDTH+1)'(DATA_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_W  = ADDR_WIDTH'(DATA_DEPTH - 1);

   if ((2**ADDR_WIDTH) < DATA_DEPTH) begin : g_chk_depth
      $error("multi_read_port_ram: 2**ADDR_WIDTH must be >= DATA_DEPTH");
   end
   if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH > MAX_DW) begin : g_chk_width
      $error("multi_read_port_ram: DATA_WIDTH must be a multiple of 8 within helper range");
   end
   if (READ_LATENCY != 0 && READ_LATENCY != 1) begin : g_chk_lat
      $error("multi_read_port_ram: READ_LATENCY must be 0 or 1");
   end
   if (NUM_RD_PORTS < 1) begin : g_chk_ports
      $error("multi_read_port_ram: NUM_RD_PORTS must be >= 1");
   end

   logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];
   clear_state_e          state;
   logic [ADDR_WIDTH-1:0] clr_cnt;
   logic                  busy;
   logic                  wr_ok;
   logic [DATA_WIDTH-1:0] wr_old;
   logic [DATA_WIDTH-1:0] wr_merged;

   assign Busy_SO = busy;

   // A write is accepted only in IDLE, outside reset, and inside the array.
   assign wr_ok     = !Rst_RI && (state == IDLE) && WrEn_SI && ({1'b0, WrAddr_DI} < DEPTH_V);
   assign wr_old    = mem[WrAddr_DI];
   assign wr_merged = DATA_WIDTH'(be_merge(MAX_DW'(wr_old), MAX_DW'(WrData_DI), MAX_NB'(WrBe_SI)));

   // Clear engine FSM. Busy is kept as its own register that mirrors state==CLEAR.
   always_ff @(posedge Clk_CI) begin
      if (Rst_RI) begin
         state   <= CLEAR;
         clr_cnt <= '0;
         busy    <= 1'b1;
      end else begin
         case (state)
            CLEAR: begin
               if (clr_cnt == LAST_W) begin
                  state   <= IDLE;
                  busy    <= 1'b0;
                  clr_cnt <= '0;
               end else begin
                  clr_cnt <= clr_cnt + 1'b1;
               end
            end
            IDLE: begin
               if (Clear_SI) begin
                  state   <= CLEAR;
                  busy    <= 1'b1;
                  clr_cnt <= '0;
               end
            end
            default: begin
               state   <= CLEAR;
               busy    <= 1'b1;
               clr_cnt <= '0;
            end
         endcase
      end
   end

   // Array update: the clear engine owns the array while clearing, otherwise the write port does.
   always_ff @(posedge Clk_CI) begin
      if (!Rst_RI && (state == CLEAR)) begin
         mem[clr_cnt] <= '0;
      end else if (wr_ok) begin
         mem[WrAddr_DI] <= wr_merged;
      end
   end

   for (genvar i = 0; i < NUM_RD_PORTS; i++) begin : g_rd
      logic [ADDR_WIDTH-1:0] rd_addr;
      logic                  in_range;
      logic [DATA_WIDTH-1:0] rd_word;

      assign rd_addr  = RdAddr_DI[i*ADDR_WIDTH +: ADDR_WIDTH];
      assign in_range = ({1'b0, rd_addr} < DEPTH_V);
      assign rd_word  = (in_range && !busy) ? mem[rd_addr] : '0;

      if (READ_LATENCY == 0) begin : g_comb
         assign RdData_DO[i*DATA_WIDTH +: DATA_WIDTH] = rd_word;
      end else begin : g_reg
         logic [DATA_WIDTH-1:0] rd_q;
         logic [DATA_WIDTH-1:0] rd_next;

         // Capture zero when the output cycle will be busy, i.e. a clear is running or starting now.
         always_comb begin
            rd_next = '0;
            if (busy || ((state == IDLE) && Clear_SI)) begin
               rd_next = '0;
            end else if ((WRITE_FIRST != 0) && wr_ok && (WrAddr_DI == rd_addr)) begin
               rd_next = wr_merged;
            end else begin
               rd_next = rd_word;
            end
         end

         // Registered read data.
         always_ff @(posedge Clk_CI) begin
            if (Rst_RI) begin
               rd_q <= '0;
            end else begin
               rd_q <= rd_next;
            end
         end

         assign RdData_DO[i*DATA_WIDTH +: DATA_WIDTH] = rd_q;
      end
   end

endmodule

// File: tb/tb_multi_read_port_ram.sv
// Scoreboard bench for multi_read_port_ram. Three instances share one stimulus:
//   u_c : depth 12, 4 ports, combinational read
//   u_w : depth 16, 2 ports, registered read, write-first
//   u_r : depth 16, 2 ports, registered read, read-first
// The stimulus pushes hand-computed expectations, tagged with the cycle on which
// they are due. A separate monitor samples on the falling edge and pops them.
module tb_multi_read_port_ram;

   logic         clk = 1'b0;
   logic         rst;
   logic         clr;
   logic         wr_en;
   logic [3:0]   wr_be;
   logic [3:0]   wr_addr;
   logic [31:0]  wr_data;
   logic [15:0]  rd_addr;
   logic [127:0] rd_c;
   logic [63:0]  rd_w;
   logic [63:0]  rd_r;
   logic         busy_c, busy_w, busy_r;

   always #5 clk = ~clk;

   multi_read_port_ram #(.ADDR_WIDTH(4), .DATA_DEPTH(12), .DATA_WIDTH(32),
      .NUM_RD_PORTS(4), .READ_LATENCY(0), .WRITE_FIRST(1)) u_c (
      .Clk_CI(clk), .Rst_RI(rst), .Clear_SI(clr), .Busy_SO(busy_c), .WrEn_SI(wr_en),
      .WrBe_SI(wr_be), .WrAddr_DI(wr_addr), .WrData_DI(wr_data),
      .RdAddr_DI(rd_addr), .RdData_DO(rd_c));

   multi_read_port_ram #(.ADDR_WIDTH(4), .DATA_DEPTH(16), .DATA_WIDTH(32),
      .NUM_RD_PORTS(2), .READ_LATENCY(1), .WRITE_FIRST(1)) u_w (
      .Clk_CI(clk), .Rst_RI(rst), .Clear_SI(clr), .Busy_SO(busy_w), .WrEn_SI(wr_en),
      .WrBe_SI(wr_be), .WrAddr_DI(wr_addr), .WrData_DI(wr_data),
      .RdAddr_DI(rd_addr[7:0]), .RdData_DO(rd_w));

   multi_read_port_ram #(.ADDR_WIDTH(4), .DATA_DEPTH(16), .DATA_WIDTH(32),
      .NUM_RD_PORTS(2), .READ_LATENCY(1), .WRITE_FIRST(0)) u_r (
      .Clk_CI(clk), .Rst_RI(rst), .Clear_SI(clr), .Busy_SO(busy_r), .WrEn_SI(wr_en),
      .WrBe_SI(wr_be), .WrAddr_DI(wr_addr), .WrData_DI(wr_data),
      .RdAddr_DI(rd_addr[7:0]), .RdData_DO(rd_r));

   typedef struct packed {
      int          due;
      int          inst;
      int          port;   // -1 selects Busy_SO
      logic [31:0] exp;
   } chk_t;

   chk_t  sb[$];
   string nm_q[$];
   int    cyc = 0;
   int    n_chk = 0;
   int    n_pass = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] actual(input int inst, input int port);
      logic [31:0] v;
      v = 32'h0;
      if (port < 0) begin
         if (inst == 0)      v = {31'b0, busy_c};
         else if (inst == 1) v = {31'b0, busy_w};
         else                v = {31'b0, busy_r};
      end else begin
         if (inst == 0)      v = rd_c[port*32 +: 32];
         else if (inst == 1) v = rd_w[port*32 +: 32];
         else                v = rd_r[port*32 +: 32];
      end
      return v;
   endfunction

   // Monitor: compare every expectation that falls due in the current cycle.
   always @(negedge clk) begin
      int i;
      logic [31:0] act;
      i = 0;
      while (i < sb.size()) begin
         if (sb[i].due == cyc) begin
            act = actual(sb[i].inst, sb[i].port);
            n_chk++;
            if (act === sb[i].exp) begin
               n_pass++;
            end else begin
               $display("FAIL %s cyc=%0d inst=%0d port=%0d got=%08h exp=%08h",
                        nm_q[i], cyc, sb[i].inst, sb[i].port, act, sb[i].exp);
            end
            sb.delete(i);
            nm_q.delete(i);
         end else begin
            i++;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_chk(input int dly, input int inst, input int port,
                          input logic [31:0] v, input string nm);
      chk_t c;
      c.due  = cyc + dly;
      c.inst = inst;
      c.port = port;
      c.exp  = v;
      sb.push_back(c);
      nm_q.push_back(nm);
   endtask

   task automatic wr(input logic en, input logic [3:0] be, input logic [3:0] a,
                     input logic [31:0] d);
      wr_en   = en;
      wr_be   = be;
      wr_addr = a;
      wr_data = d;
   endtask

   initial begin
      logic [3:0] a;
      logic [3:0] lst [5];
      rst = 1'b1; clr = 1'b0; rd_addr = 16'h0;
      wr(1'b0, 4'h0, 4'h0, 32'h0);
      step();                              // reset sampled on the first edge
      rst = 1'b0;

      // Busy stays high for exactly DATA_DEPTH cycles after reset falls.
      for (int k = 0; k < 16; k++) exp_chk(k, 1, -1, 32'h1, "busy_w_hold");
      exp_chk(16, 1, -1, 32'h0, "busy_w_fall");
      exp_chk(15, 2, -1, 32'h1, "busy_r_last");
      exp_chk(16, 2, -1, 32'h0, "busy_r_fall");
      exp_chk(11, 0, -1, 32'h1, "busy_c_last");
      exp_chk(12, 0, -1, 32'h0, "busy_c_fall");
      wr(1'b1, 4'hF, 4'd2, 32'hFFFF_FFFF);  // dropped: engine busy
      exp_chk(0, 0, 0, 32'h0, "rd_busy_c");
      step();
      wr(1'b0, 4'h0, 4'h0, 32'h0);
      repeat (15) step();                  // now first idle cycle of u_w

      n_chk++;
      if (busy_w === 1'b0) begin
         n_pass++;
      end else begin
         $display("FAIL direct busy_w idle got=%b", busy_w);
      end
      n_chk++;
      if (busy_r === 1'b0) begin
         n_pass++;
      end else begin
         $display("FAIL direct busy_r idle got=%b", busy_r);
      end
      n_chk++;
      if (busy_c === 1'b0) begin
         n_pass++;
      end else begin
         $display("FAIL direct busy_c idle got=%b", busy_c);
      end

      // Every address reads zero after the reset clear.
      for (int k = 0; k < 16; k++) begin
         a = 4'(k);
         rd_addr = {a, a, a, a};
         exp_chk(0, 0, k % 4, 32'h0, "sweep_c");
         exp_chk(1, 1, 0, 32'h0, "sweep_w");
         exp_chk(1, 2, 1, 32'h0, "sweep_r");
         step();
      end

      // Byte-enable merge and same-cycle read behaviour on addr 3.
      rd_addr = {4'd3, 4'd3, 4'd3, 4'd3};
      wr(1'b1, 4'hF, 4'd3, 32'h1122_3344);
      exp_chk(0, 0, 0, 32'h0, "rbw_c");
      exp_chk(1, 1, 0, 32'h1122_3344, "wf_new");
      exp_chk(1, 2, 0, 32'h0, "rf_old");
      step();
      wr(1'b1, 4'b0101, 4'd3, 32'hDEAD_BEEF);
      exp_chk(0, 0, 0, 32'h1122_3344, "wr_full_c");
      exp_chk(1, 1, 0, 32'h11AD_33EF, "wf_be_merge");
      exp_chk(1, 2, 0, 32'h1122_3344, "rf_old2");
      step();
      wr(1'b1, 4'h0, 4'd3, 32'hFFFF_FFFF);  // no bytes enabled
      exp_chk(0, 0, 1, 32'h11AD_33EF, "be_merge_c");
      exp_chk(1, 1, 0, 32'h11AD_33EF, "wf_be0");
      exp_chk(1, 2, 0, 32'h11AD_33EF, "rf_be0");
      step();
      wr(1'b0, 4'h0, 4'd0, 32'h0);
      exp_chk(0, 0, 2, 32'h11AD_33EF, "be0_c");
      step();

      // All ports on one address, then write-first vs read-first on addr 7.
      wr(1'b1, 4'hF, 4'd5, 32'hA5A5_A5A5);
      step();
      wr(1'b1, 4'hF, 4'd7, 32'h0BAD_F00D);
      rd_addr = {4'd5, 4'd5, 4'd5, 4'd5};
      for (int p = 0; p < 4; p++) exp_chk(0, 0, p, 32'hA5A5_A5A5, "same_addr_c");
      for (int p = 0; p < 2; p++) exp_chk(1, 1, p, 32'hA5A5_A5A5, "same_addr_w");
      for (int p = 0; p < 2; p++) exp_chk(1, 2, p, 32'hA5A5_A5A5, "same_addr_r");
      step();
      wr(1'b1, 4'hF, 4'd7, 32'h1234_5678);
      rd_addr = {4'd5, 4'd3, 4'd5, 4'd7};
      exp_chk(0, 0, 0, 32'h0BAD_F00D, "mix_p0_c");
      exp_chk(0, 0, 1, 32'hA5A5_A5A5, "mix_p1_c");
      exp_chk(0, 0, 2, 32'h11AD_33EF, "mix_p2_c");
      exp_chk(0, 0, 3, 32'hA5A5_A5A5, "mix_p3_c");
      exp_chk(1, 1, 0, 32'h1234_5678, "wf_addr7");
      exp_chk(1, 1, 1, 32'hA5A5_A5A5, "wf_p1");
      exp_chk(1, 2, 0, 32'h0BAD_F00D, "rf_addr7");
      step();
      wr(1'b0, 4'h0, 4'd0, 32'h0);

      n_chk++;
      if (rd_w[31:0] === 32'h1234_5678) begin
         n_pass++;
      end else begin
         $display("FAIL direct wf_addr7 got=%08h", rd_w[31:0]);
      end
      n_chk++;
      if (rd_r[31:0] === 32'h0BAD_F00D) begin
         n_pass++;
      end else begin
         $display("FAIL direct rf_addr7 got=%08h", rd_r[31:0]);
      end
      n_chk++;
      if (rd_c[31:0] === 32'h1234_5678) begin
         n_pass++;
      end else begin
         $display("FAIL direct addr7_c got=%08h", rd_c[31:0]);
      end

      exp_chk(0, 0, 0, 32'h1234_5678, "addr7_c");
      exp_chk(1, 2, 0, 32'h1234_5678, "addr7_r");
      step();

      // Out-of-range write on the depth-12 instance (in range on depth 16).
      wr(1'b1, 4'hF, 4'd13, 32'hCAFE_F00D);
      rd_addr = {4'd1, 4'd1, 4'd1, 4'd13};
      step();
      wr(1'b0, 4'h0, 4'd0, 32'h0);
      exp_chk(0, 0, 0, 32'h0, "oor_rd_c");
      exp_chk(0, 0, 1, 32'h0, "alias_addr1_c");
      exp_chk(1, 1, 0, 32'hCAFE_F00D, "addr13_w");
      exp_chk(1, 1, 1, 32'h0, "addr1_w");
      step();
      step();

      // Clear request with data stored; a write and a second pulse during the clear.
      clr = 1'b1;
      rd_addr = {4'd5, 4'd5, 4'd5, 4'd5};
      exp_chk(0, 0, 0, 32'hA5A5_A5A5, "pre_clear_c");
      exp_chk(1, 1, 0, 32'h0, "clr_start_w");
      exp_chk(1, 2, 0, 32'h0, "clr_start_r");
      exp_chk(1, 1, -1, 32'h1, "clr_busy_w");
      exp_chk(16, 1, -1, 32'h1, "clr_busy_w_last");
      exp_chk(17, 1, -1, 32'h0, "clr_busy_w_fall");
      exp_chk(12, 0, -1, 32'h1, "clr_busy_c_last");
      exp_chk(13, 0, -1, 32'h0, "clr_busy_c_fall");
      step();
      clr = 1'b0;
      wr(1'b1, 4'hF, 4'd3, 32'hFFFF_FFFF);
      exp_chk(0, 0, 0, 32'h0, "rd_in_clear_c");
      step();
      wr(1'b0, 4'h0, 4'd0, 32'h0);
      clr = 1'b1;                          // ignored while clearing
      step();
      clr = 1'b0;
      repeat (14) step();
      lst[0] = 4'd3; lst[1] = 4'd5; lst[2] = 4'd7; lst[3] = 4'd13; lst[4] = 4'd1;
      for (int k = 0; k < 5; k++) begin
         rd_addr = {lst[k], lst[k], lst[k], lst[k]};
         exp_chk(0, 0, 0, 32'h0, "post_clear_c");
         exp_chk(1, 1, 0, 32'h0, "post_clear_w");
         exp_chk(1, 2, 1, 32'h0, "post_clear_r");
         step();
      end

      // Reset in the middle of a clear restarts it from word 0.
      clr = 1'b1;
      step();
      clr = 1'b0;
      repeat (4) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      exp_chk(15, 1, -1, 32'h1, "rst_restart_w_last");
      exp_chk(16, 1, -1, 32'h0, "rst_restart_w_fall");
      exp_chk(11, 0, -1, 32'h1, "rst_restart_c_last");
      exp_chk(12, 0, -1, 32'h0, "rst_restart_c_fall");
      repeat (20) step();

      // Anything left unsampled is a failure.
      while (sb.size() > 0) begin
         n_chk++;
         $display("FAIL %s never sampled due=%0d exp=%08h", nm_q[0], sb[0].due, sb[0].exp);
         sb.delete(0);
         nm_q.delete(0);
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
